alu_mul_unit: RTL
=================

ALU_MUL_UNIT -- requirements
Module: alu_mul_unit

Interface
REQ-001: The block SHALL have one clock and an asynchronous, active-high reset; ports SHALL be exactly as listed below.
REQ-002: clk_i  input  1  clock; all state changes on rising edge.
REQ-003: rst_i  input  1  reset, asynchronous, active-high.
REQ-004: start_i  input  1  request valid; sampled only at a rising edge while busy_o=0.
REQ-005: ALUCtrl_i  input  4  operation code from ALU control: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, 0011 mul.
REQ-006: src1_i  input  32  operand A.
REQ-007: src2_i  input  32  operand B.
REQ-008: result_o  output  32  registered result of last completed operation.
REQ-009: zero_o  output  1  combinational, 1 when result_o == 0.
REQ-010: busy_o  output  1  1 while a multiply is iterating; new requests are not accepted.
REQ-011: done_o  output  1  one-cycle pulse marking that result_o was just updated.

Function
REQ-012: FSM SHALL have two states, IDLE and MUL; busy_o SHALL be 1 exactly when the state is MUL.
REQ-013: IDLE, start_i=1, ALUCtrl_i≠0011 -> at that edge result_o loads the single-cycle result, done_o=1 for the following cycle, state stays IDLE (latency 1).
REQ-014: add/sub SHALL be 32-bit modulo, with overflow wrapping silently and no flag.
REQ-015: and/or SHALL be bitwise.
REQ-016: slt SHALL give 32'd1 if src1_i < src2_i as signed two's complement, else 32'd0, correct even when src1_i - src2_i overflows.
REQ-017: An undefined ALUCtrl_i SHALL produce result_o = 0 with a normal single-cycle done_o pulse.
REQ-018: IDLE, start_i=1, ALUCtrl_i=0011 -> at that edge latch multiplicand=src1_i, multiplier=src2_i, acc=0, count=0; go to MUL; done_o=0.
REQ-019: MUL, each edge: if multiplier[0] then acc += multiplicand (mod 2^32); multiplicand <<= 1; multiplier >>= 1; count += 1.
REQ-020: The 32nd iteration edge SHALL load result_o with the final acc (low 32 bits of product, sign-agnostic), return to IDLE, and assert done_o for the next cycle.
REQ-021: busy_o SHALL be high for exactly 32 cycles after the accepting edge; done_o SHALL rise 32 cycles after the accepting edge.
REQ-022: There SHALL be no early termination: multiply latency is fixed at 32 regardless of operand values.
REQ-023: start_i while busy_o=1 SHALL be ignored with no queuing, and operand/ALUCtrl_i changes during MUL SHALL have no effect.
REQ-024: start_i asserted on the same edge that completes a multiply (busy_o=1 before the edge) SHALL be ignored.
REQ-025: result_o SHALL hold its value between completions; done_o SHALL be 0 in every cycle not specified above.
REQ-026: Back-to-back single-cycle requests SHALL be accepted every cycle, each producing its own done_o pulse.

Reset
REQ-027: rst_i=1 SHALL immediately force state IDLE, result_o=0, zero_o=1, busy_o=0, done_o=0, and acc/count/multiplicand/multiplier=0.
REQ-028: Reset mid-multiply SHALL abort the operation with no done_o pulse; the first request after deassertion SHALL be processed normally.
REQ-029: start_i SHALL be ignored while rst_i=1.

Verification
REQ-030: add 5 + 7 -> next cycle result_o=12, done_o=1 for one cycle, zero_o=0; then sub 3 - 3 -> result_o=0, zero_o=1.
REQ-031: slt src1=0x80000000, src2=0x00000001 -> result_o=1; slt src1=0x7FFFFFFF, src2=0x80000000 -> result_o=0.
REQ-032: mul 6 × 7 -> busy_o high 32 cycles, done_o pulse 32 cycles after accept, result_o=42; mul 0xFFFFFFFF × 3 -> 0xFFFFFFFD.
REQ-033: During mul 6 × 7, pulse start_i with add 1 + 1 at cycle 5 -> ignored; final result_o=42, exactly one done_o pulse.
REQ-034: Assert rst_i at cycle 10 of a multiply -> busy_o=0 and result_o=0 at once, no done_o; then add 2 + 2 -> result_o=4 next cycle.
REQ-035: Undefined ALUCtrl_i=1111 with src1=src2=0xFFFF -> result_o=0, zero_o=1, single done_o pulse.

Source files
------------

// File: rtl/alu_mul_unit.sv
// alu_mul_unit
//   Single-cycle ALU (add, sub, and, or, slt) plus a 32-iteration
//   shift-and-add multiplier sharing one registered result.
//
//   clk_i      : clock, all state changes on the rising edge
//   rst_i      : asynchronous active-high reset
//   start_i    : request valid, sampled only while busy_o = 0
//   ALUCtrl_i  : operation code (0010 add, 0110 sub, 0000 and, 0001 or,
//                0111 slt, 0011 mul; anything else yields 0)
//   src1_i     : operand A
//   src2_i     : operand B
//   result_o   : registered result of the last completed operation
//   zero_o     : 1 when result_o == 0
//   busy_o     : 1 while a multiply is iterating
//   done_o     : one-cycle pulse, result_o was just updated
module alu_mul_unit (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [3:0]  ALUCtrl_i,
   input  logic [31:0] src1_i,
   input  logic [31:0] src2_i,
   output logic [31:0] result_o,
   output logic        zero_o,
   output logic        busy_o,
   output logic        done_o
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_MUL = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   state_t      state_r;
   logic [31:0] result_r;
   logic        done_r;
   logic [31:0] acc_r;
   logic [31:0] mcand_r;
   logic [31:0] mplier_r;
   logic [4:0]  count_r;

   logic [31:0] alu_result_s;
   logic [31:0] acc_next_s;

   // Single-cycle ALU result; mul and undefined codes produce 0 here.
   always_comb begin
      alu_result_s = 32'd0;
      case (ALUCtrl_i)
         OP_ADD:  alu_result_s = src1_i + src2_i;
         OP_SUB:  alu_result_s = src1_i - src2_i;
         OP_AND:  alu_result_s = src1_i & src2_i;
         OP_OR:   alu_result_s = src1_i | src2_i;
         // Signed compare directly, so overflow of src1-src2 cannot flip it.
         OP_SLT:  alu_result_s = ($signed(src1_i) < $signed(src2_i)) ? 32'd1 : 32'd0;
         OP_MUL:  alu_result_s = 32'd0;
         default: alu_result_s = 32'd0;
      endcase
   end

   // Accumulator value after the current multiply iteration.
   always_comb begin
      acc_next_s = acc_r;
      if (mplier_r[0]) begin
         acc_next_s = acc_r + mcand_r;
      end else begin
         acc_next_s = acc_r;
      end
   end

   // Control FSM with datapath registers; done_r defaults low every cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r  <= ST_IDLE;
         result_r <= 32'd0;
         done_r   <= 1'b0;
         acc_r    <= 32'd0;
         mcand_r  <= 32'd0;
         mplier_r <= 32'd0;
         count_r  <= 5'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start_i) begin
                  if (ALUCtrl_i == OP_MUL) begin
                     mcand_r  <= src1_i;
                     mplier_r <= src2_i;
                     acc_r    <= 32'd0;
                     count_r  <= 5'd0;
                     state_r  <= ST_MUL;
                  end else begin
                     result_r <= alu_result_s;
                     done_r   <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
               acc_r    <= acc_next_s;
               mcand_r  <= mcand_r << 1;
               mplier_r <= mplier_r >> 1;
               count_r  <= count_r + 5'd1;
               // Fixed 32 iterations; the last one publishes the product.
               if (count_r == 5'd31) begin
                  result_r <= acc_next_s;
                  done_r   <= 1'b1;
                  state_r  <= ST_IDLE;
               end else begin
                  done_r   <= 1'b0;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign result_o = result_r;
   assign zero_o   = (result_r == 32'd0);
   assign busy_o   = (state_r == ST_MUL);
   assign done_o   = done_r;

endmodule
